// File: rtl/maze_packet_tx.sv
// maze_packet_tx
// Queues maze position updates in a 4-entry FIFO and plays each one out on a
// GPIO-style packet bus: PACKET_OUT is set up, strobed, then held through a
// gap before the next entry is taken. An entry identical to the last packet
// sent is dropped silently so the receiver only sees real moves.
//
// Handshake: an update transfers on a rising CLOCK edge where POS_VALID and
// POS_READY are both high. POS_READY is a function of registered FIFO state
// only, so it never depends on POS_VALID in the same cycle.
//
// Ports
//   CLOCK          in   block clock, rising edge
//   RESET_N        in   asynchronous active-low reset
//   POS_VALID      in   position update offered
//   POS_ROW[1:0]   in   grid row 0-3
//   POS_COL[2:0]   in   grid column, 0-4 legal
//   POS_READY      out  FIFO not full
//   PACKET_OUT[4:0]out  {col,row} of the packet on the bus
//   PACKET_STROBE  out  packet-valid qualifier
//   POS_ERR        out  one-cycle pulse after an illegal column is accepted
//   BUSY           out  FIFO non-empty or transmitter not idle
//   DBG_STATE[1:0] out  transmitter FSM state (debug observation)
module maze_packet_tx #(
    parameter int SETUP_CYC  = 4,
    parameter int STROBE_CYC = 8,
    parameter int GAP_CYC    = 4
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic       POS_VALID,
    input  logic [1:0] POS_ROW,
    input  logic [2:0] POS_COL,
    output logic       POS_READY,
    output logic [4:0] PACKET_OUT,
    output logic       PACKET_STROBE,
    output logic       POS_ERR,
    output logic       BUSY,
    output logic [1:0] DBG_STATE
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] STROBE = 2'd2;
    localparam logic [1:0] GAP    = 2'd3;

    localparam logic [7:0] SETUP_LOAD  = 8'(SETUP_CYC - 1);
    localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYC - 1);
    localparam logic [7:0] GAP_LOAD    = 8'(GAP_CYC - 1);

    // FIFO storage and pointers
    logic [4:0] fifo_mem_q [4];
    logic [1:0] wr_ptr_q;
    logic [1:0] rd_ptr_q;
    logic [2:0] count_q;

    // Transmitter state
    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [4:0] out_q, out_d;
    logic [4:0] last_q, last_d;
    logic       last_valid_q, last_valid_d;
    logic       strobe_q, strobe_d;
    logic       err_q;

    logic       accept;
    logic       col_ok;
    logic       push;
    logic       pop;
    logic [4:0] head;

    assign POS_READY = (count_q != 3'd4);
    assign accept    = POS_VALID && POS_READY;
    assign col_ok    = (POS_COL <= 3'd4);
    assign push      = accept && col_ok;
    assign head      = fifo_mem_q[rd_ptr_q];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        out_d        = out_q;
        last_d       = last_q;
        last_valid_d = last_valid_q;
        strobe_d     = strobe_q;
        pop          = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != 3'd0) begin
                    pop = 1'b1;
                    // A repeat of the last packet is consumed but not sent.
                    if (!(last_valid_q && (head == last_q))) begin
                        out_d        = head;
                        last_d       = head;
                        last_valid_d = 1'b1;
                        state_d      = SETUP;
                        cnt_d        = SETUP_LOAD;
                    end
                end
            end
            SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d  = STROBE;
                    cnt_d    = STROBE_LOAD;
                    strobe_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            STROBE: begin
                if (cnt_q == 8'd0) begin
                    state_d  = GAP;
                    cnt_d    = GAP_LOAD;
                    strobe_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            GAP: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = 8'd0;
                strobe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            out_q        <= 5'd0;
            last_q       <= 5'd0;
            last_valid_q <= 1'b0;
            strobe_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_q        <= out_d;
            last_q       <= last_d;
            last_valid_q <= last_valid_d;
            strobe_q     <= strobe_d;
            err_q        <= accept && !col_ok;
        end
    end

    // Pointers and count; a simultaneous push and pop leaves the count alone.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry contents need no reset: they are only read while count is non-zero.
    always_ff @(posedge CLOCK) begin
        if (push) fifo_mem_q[wr_ptr_q] <= {POS_COL, POS_ROW};
    end

    assign PACKET_OUT    = out_q;
    assign PACKET_STROBE = strobe_q;
    assign POS_ERR       = err_q;
    assign BUSY          = (count_q != 3'd0) || (state_q != IDLE);
    assign DBG_STATE     = state_q;

endmodule

// File: doc/maze_packet_tx.md
MAZE_PACKET_TX -- requirements
Module: maze_packet_tx

Interface
REQ-001 Parameter SETUP_CYC, default 4: cycles PACKET_OUT is stable before PACKET_STROBE rises; legal range 1-255.
REQ-002 Parameter STROBE_CYC, default 8: cycles PACKET_STROBE is held high; legal range 1-255.
REQ-003 Parameter GAP_CYC, default 4: cycles PACKET_STROBE is held low after the strobe before the next pop; legal range 1-255.
REQ-004 Port CLOCK, input, 1: single clock for the block; all state changes on its rising edge.
REQ-005 Port RESET_N, input, 1: reset, asynchronous and active-low.
REQ-006 Port POS_VALID, input, 1: position update offered.
REQ-007 Port POS_ROW, input, 2: grid row, 0-3.
REQ-008 Port POS_COL, input, 3: grid column, 0-4 legal.
REQ-009 Port POS_READY, output, 1: block can accept an update.
REQ-010 Port PACKET_OUT, output, 5: encoded position driven to the GPIO packet lines.
REQ-011 Port PACKET_STROBE, output, 1: packet-valid qualifier.
REQ-012 Port POS_ERR, output, 1: one-cycle pulse when an update with an illegal column is accepted.
REQ-013 Port BUSY, output, 1: high while the FIFO is non-empty or the FSM is not in IDLE.

Function
REQ-014 Encoding SHALL be PACKET_OUT = {POS_COL[2:0], POS_ROW[1:0]}; for example row 1, col 1 -> 5'b00101 and row 3, col 4 -> 5'b10011.
REQ-015 An update SHALL be accepted on a rising edge where POS_VALID=1 and POS_READY=1.
REQ-016 POS_READY SHALL equal NOT full of a 4-entry FIFO; it SHALL depend on registered state only, with no combinational path from POS_VALID.
REQ-017 An accepted update with POS_COL > 4 SHALL NOT be written to the FIFO; POS_ERR SHALL be 1 for exactly the following cycle.
REQ-018 A FIFO push and pop on the same edge SHALL both take effect; the FIFO count SHALL remain unchanged.
REQ-019 The FSM SHALL have states IDLE, SETUP, STROBE and GAP, plus an 8-bit down-counter.
REQ-020 IDLE with FIFO non-empty: the block SHALL pop the head entry on the next edge.
  - If the entry equals the last-sent packet and the last-valid flag is set: discard it, remain in IDLE, leave PACKET_OUT unchanged.
  - Otherwise: load PACKET_OUT and the last-sent register, set the last-valid flag, go to SETUP with counter = SETUP_CYC-1.
REQ-021 SETUP: when the counter reaches 0, go to STROBE with counter = STROBE_CYC-1 and PACKET_STROBE=1.
REQ-022 STROBE: when the counter reaches 0, go to GAP with counter = GAP_CYC-1 and PACKET_STROBE=0.
REQ-023 GAP: when the counter reaches 0, go to IDLE.
REQ-024 PACKET_OUT SHALL change only on the IDLE->SETUP edge and SHALL stay stable through SETUP, STROBE and GAP.
REQ-025 Timing for an update accepted at edge E into an empty FIFO with the FSM in IDLE:
  - PACKET_OUT updates at edge E+1.
  - PACKET_STROBE rises at E+1+SETUP_CYC.
  - PACKET_STROBE falls at E+1+SETUP_CYC+STROBE_CYC.
  - The FSM returns to IDLE at E+1+SETUP_CYC+STROBE_CYC+GAP_CYC.
REQ-026 Back-to-back distinct packets SHALL be spaced exactly SETUP_CYC+STROBE_CYC+GAP_CYC+1 cycles apart at PACKET_OUT.
REQ-027 FIFO pointers SHALL be 2 bits and wrap from 3 to 0; the count SHALL be 3 bits (0-4).

Reset
REQ-028 While RESET_N=0, independent of CLOCK, the block SHALL force:
  - FSM = IDLE, counter = 0, FIFO empty, last-valid flag = 0, last-sent register = 0;
  - PACKET_OUT = 0, PACKET_STROBE = 0, POS_ERR = 0, BUSY = 0, POS_READY = 1.
REQ-029 Assertion of RESET_N mid-transfer SHALL drop PACKET_STROBE immediately and discard all queued entries.
REQ-030 The first packet after reset SHALL be transmitted even if it equals 5'b00000.

Verification
REQ-031 Defaults; single update row 2, col 2 at edge E:
  -> PACKET_OUT = 5'b01010 at E+1;
  -> PACKET_STROBE high from E+5 to E+13;
  -> BUSY low from E+17.
REQ-032 Five updates presented on consecutive cycles while a transfer is in progress:
  -> POS_READY low after the 4th accept;
  -> the 5th is held until a pop, then accepted;
  -> all five packets emerge in order, 17 cycles apart.
REQ-033 Updates (1,1), (1,1), (2,1):
  -> exactly two strobes, with PACKET_OUT 5'b00101 then 5'b00110.
REQ-034 Update row 0, col 6:
  -> POS_ERR pulses once;
  -> no strobe;
  -> FIFO count unchanged.
REQ-035 RESET_N low during STROBE with 2 entries queued:
  -> PACKET_STROBE = 0 and PACKET_OUT = 0 immediately;
  -> after release, a (0,0) update is sent as 5'b00000 with a strobe.
